alu_sched: RTL and testbench

- Shares one RV32I ALU between N_REQ requesters, for example the EX-stage operand path and the branch-target/compare path.
- Arbitrates round-robin, drives the ALU's op and operand inputs, and captures the ALU result into a single-entry result register tagged with the requester index.
- Valid/ready on both sides.
- The ALU itself is instantiated alongside this block and connected through the alu_* ports.

---
 rtl/core_types_pkg.sv | 21 ++
 rtl/dl_rr_arb.sv | 37 +++
 rtl/alu_sched.sv | 123 ++++++++++++
 tb/tb_alu_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_types_pkg.sv
// Shared core types: ALU op encoding (RV32I funct3-style opcode plus SUB/SRA
// select) and requester-count limit for the shared-ALU scheduler.
package core_types_pkg;

  typedef struct packed {
    logic [2:0] alu_opcode;
    logic       aux_sel;
  } alu_op_t;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SLL  = 3'd1;
  localparam logic [2:0] ALU_SLT  = 3'd2;
  localparam logic [2:0] ALU_SLTU = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SR   = 3'd5;
  localparam logic [2:0] ALU_OR   = 3'd6;
  localparam logic [2:0] ALU_AND  = 3'd7;

  localparam int ALU_SCHED_MAX_REQ = 8;

endpackage

// File: rtl/dl_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first active request at or after
// ptr (with wrap). en=0 suppresses the grant and forces gnt_idx to 0.
module dl_rr_arb #(
  parameter  int N_REQ = 2,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx
);

  logic            found;
  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // one spare bit so ptr+k can exceed N_REQ-1 before the wrap
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
      idx = sum[ID_W-1:0];
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one ALU between N_REQ requesters: round-robin issue, 1-cycle result
// register tagged with requester id. Optional counters under ALU_SCHED_PERF_EN.
module alu_sched import core_types_pkg::*; #(
  parameter  int N_BITS = 32,
  parameter  int N_REQ  = 2,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  alu_op_t [N_REQ-1:0]           req_op,
  input  logic [N_REQ-1:0][N_BITS-1:0]  req_in0,
  input  logic [N_REQ-1:0][N_BITS-1:0]  req_in1,
  output alu_op_t                       alu_op,
  output logic [N_BITS-1:0]             alu_in0,
  output logic [N_BITS-1:0]             alu_in1,
  input  logic [N_BITS-1:0]             alu_out,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_W-1:0]               resp_id,
  output logic [N_BITS-1:0]             resp_data
`ifdef ALU_SCHED_PERF_EN
  ,
  output logic [N_REQ-1:0][31:0]        perf_grant_cnt,
  output logic [31:0]                   perf_stall_cnt
`endif
);

  logic              can_issue, accept;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic [N_BITS-1:0] resp_data_q, resp_data_d;

  assign can_issue = !resp_valid_q || resp_ready;

  generate
    if (N_REQ == 1) begin : g_single
      assign gnt     = req_valid & {N_REQ{can_issue}};
      assign gnt_idx = '0;
    end else begin : g_arb
      logic [ID_W-1:0] ptr_q, ptr_d;

      dl_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (can_issue),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
      );

      always_comb begin
        ptr_d = ptr_q;
        if (accept)
          ptr_d = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
      end
    end
  endgenerate

  assign req_ready = gnt;
  assign accept    = |gnt;

  // gnt_idx is 0 without a grant, so idle cycles show requester 0's fields
  assign alu_op  = req_op[gnt_idx];
  assign alu_in0 = req_in0[gnt_idx];
  assign alu_in1 = req_in1[gnt_idx];

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_id_d    = gnt_idx;
      resp_data_d  = alu_out;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;

`ifdef ALU_SCHED_PERF_EN
  logic [31:0] grant_cnt_q [N_REQ];
  logic [31:0] stall_cnt_q;

  for (genvar r = 0; r < N_REQ; r++) begin : g_perf
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      grant_cnt_q[r] <= '0;
      else if (gnt[r]) grant_cnt_q[r] <= grant_cnt_q[r] + 32'd1;
    end
    assign perf_grant_cnt[r] = grant_cnt_q[r];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      stall_cnt_q <= '0;
    else if (|req_valid && !accept)  stall_cnt_q <= stall_cnt_q + 32'd1;
  end
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: directed vector table (N_REQ=2), wrap/reset sequences,
// and randomized traffic (N_REQ=3) against a queue-free behavioural model.
module tb_alu_sched;
  import core_types_pkg::*;

  localparam alu_op_t OP_ADD = '{alu_opcode: 3'd0, aux_sel: 1'b0};
  localparam alu_op_t OP_SUB = '{alu_opcode: 3'd0, aux_sel: 1'b1};
  localparam alu_op_t OP_XOR = '{alu_opcode: 3'd4, aux_sel: 1'b0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] alu_f(alu_op_t op, logic [31:0] a, logic [31:0] b);
    case (op.alu_opcode)
      3'd0: return op.aux_sel ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return op.aux_sel ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // N_REQ=2 instance
  logic [1:0]        v2, rdy2;
  alu_op_t [1:0]     op2;
  logic [1:0][31:0]  a2, b2;
  alu_op_t           aop2;
  logic [31:0]       ai0_2, ai1_2, ao2, d2;
  logic              rv2, rr2;
  logic              id2;
  assign ao2 = alu_f(aop2, ai0_2, ai1_2);

  // N_REQ=3 instance
  logic [2:0]        v3, rdy3;
  alu_op_t [2:0]     op3;
  logic [2:0][31:0]  a3, b3;
  alu_op_t           aop3;
  logic [31:0]       ai0_3, ai1_3, ao3, d3;
  logic              rv3, rr3;
  logic [1:0]        id3;
  assign ao3 = alu_f(aop3, ai0_3, ai1_3);

`ifdef ALU_SCHED_PERF_EN
  logic [1:0][31:0] pg2;
  logic [31:0]      ps2;
  logic [2:0][31:0] pg3;
  logic [31:0]      ps3;
`endif

  alu_sched #(.N_BITS(32), .N_REQ(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(rdy2), .req_op(op2),
    .req_in0(a2), .req_in1(b2), .alu_op(aop2), .alu_in0(ai0_2), .alu_in1(ai1_2),
    .alu_out(ao2), .resp_valid(rv2), .resp_ready(rr2), .resp_id(id2), .resp_data(d2)
`ifdef ALU_SCHED_PERF_EN
    , .perf_grant_cnt(pg2), .perf_stall_cnt(ps2)
`endif
  );

  alu_sched #(.N_BITS(32), .N_REQ(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3), .req_op(op3),
    .req_in0(a3), .req_in1(b3), .alu_op(aop3), .alu_in0(ai0_3), .alu_in1(ai1_3),
    .alu_out(ao3), .resp_valid(rv3), .resp_ready(rr3), .resp_id(id3), .resp_data(d3)
`ifdef ALU_SCHED_PERF_EN
    , .perf_grant_cnt(pg3), .perf_stall_cnt(ps3)
`endif
  );

  typedef struct {
    logic [1:0]  v;
    alu_op_t     op0;
    logic [31:0] a0, b0;
    alu_op_t     op1;
    logic [31:0] a1, b1;
    logic        rr;
    logic [1:0]  e_rdy;
    logic        e_rv;
    logic [31:0] e_d;
    logic        e_id;
  } vec_t;

  function automatic vec_t mk(logic [1:0] v, alu_op_t op0, logic [31:0] a0, logic [31:0] b0,
                              alu_op_t op1, logic [31:0] a1, logic [31:0] b1, logic rr,
                              logic [1:0] e_rdy, logic e_rv, logic [31:0] e_d, logic e_id);
    vec_t t;
    t.v = v; t.op0 = op0; t.a0 = a0; t.b0 = b0; t.op1 = op1; t.a1 = a1; t.b1 = b1;
    t.rr = rr; t.e_rdy = e_rdy; t.e_rv = e_rv; t.e_d = e_d; t.e_id = e_id;
    return t;
  endfunction

  vec_t vecs [12];

  initial begin
    int eg [4];
    int m_ptr, g, idx;
    logic m_rv;
    logic [31:0] m_d;
    logic [1:0]  m_id;
    logic [2:0]  hold, exp_rdy;

    // single request, contention 0,1,0,1, backpressure, drain+accept, drain
    vecs[0]  = mk(2'b01, OP_ADD, 5, 7,    OP_ADD, 0, 0,        1'b1, 2'b01, 1'b0, 0,     1'b0);
    vecs[1]  = mk(2'b10, OP_ADD, 5, 7,    OP_ADD, 1, 1,        1'b1, 2'b10, 1'b1, 12,    1'b0);
    vecs[2]  = mk(2'b11, OP_SUB, 10, 3,   OP_XOR, 'hF0, 'h0F,  1'b1, 2'b01, 1'b1, 2,     1'b1);
    vecs[3]  = mk(2'b11, OP_SUB, 10, 3,   OP_XOR, 'hF0, 'h0F,  1'b1, 2'b10, 1'b1, 7,     1'b0);
    vecs[4]  = mk(2'b11, OP_SUB, 10, 3,   OP_XOR, 'hF0, 'h0F,  1'b1, 2'b01, 1'b1, 'hFF,  1'b1);
    vecs[5]  = mk(2'b11, OP_SUB, 10, 3,   OP_XOR, 'hF0, 'h0F,  1'b1, 2'b10, 1'b1, 7,     1'b0);
    vecs[6]  = mk(2'b11, OP_SUB, 10, 3,   OP_XOR, 'hF0, 'h0F,  1'b0, 2'b00, 1'b1, 'hFF,  1'b1);
    vecs[7]  = mk(2'b11, OP_SUB, 10, 3,   OP_XOR, 'hF0, 'h0F,  1'b0, 2'b00, 1'b1, 'hFF,  1'b1);
    vecs[8]  = mk(2'b11, OP_SUB, 10, 3,   OP_XOR, 'hF0, 'h0F,  1'b0, 2'b00, 1'b1, 'hFF,  1'b1);
    vecs[9]  = mk(2'b11, OP_SUB, 10, 3,   OP_XOR, 'hF0, 'h0F,  1'b1, 2'b01, 1'b1, 'hFF,  1'b1);
    vecs[10] = mk(2'b00, OP_SUB, 10, 3,   OP_XOR, 'hF0, 'h0F,  1'b1, 2'b00, 1'b1, 7,     1'b0);
    vecs[11] = mk(2'b00, OP_SUB, 10, 3,   OP_XOR, 'hF0, 'h0F,  1'b1, 2'b00, 1'b0, 0,     1'b0);

    rst_n = 1'b0;
    v2 = '0; op2 = '0; a2 = '0; b2 = '0; rr2 = 1'b0;
    v3 = '0; op3 = '0; a3 = '0; b3 = '0; rr3 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rv", 32'(rv2), 0);
    chk("reset_id", 32'(id2), 0);
    chk("reset_data", d2, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      v2 = vecs[i].v; op2[0] = vecs[i].op0; a2[0] = vecs[i].a0; b2[0] = vecs[i].b0;
      op2[1] = vecs[i].op1; a2[1] = vecs[i].a1; b2[1] = vecs[i].b1; rr2 = vecs[i].rr;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(rdy2), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_rv", i), 32'(rv2), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) begin
        chk($sformatf("vec%0d_data", i), d2, vecs[i].e_d);
        chk($sformatf("vec%0d_id", i), 32'(id2), 32'(vecs[i].e_id));
      end
      @(negedge clk);
    end

    // wrap-around on N_REQ=3: move pointer to 2, then only 2 and 0 contend
    rr3 = 1'b1; v3 = 3'b010; op3[1] = OP_ADD; a3[1] = 1; b3[1] = 1;
    #1 chk("wrap_setup_ready", 32'(rdy3), 32'b010);
    @(negedge clk);
    v3 = 3'b101; op3[0] = OP_ADD; a3[0] = 100; b3[0] = 0; op3[2] = OP_ADD; a3[2] = 200; b3[2] = 0;
    eg = '{2, 0, 2, 0};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("wrap%0d_ready", i), 32'(rdy3), 32'(1 << eg[i]));
      chk($sformatf("wrap%0d_rv", i), 32'(rv3), 1);
      chk($sformatf("wrap%0d_id", i), 32'(id3), (i == 0) ? 1 : 32'(eg[i-1]));
      @(negedge clk);
    end
    v3 = '0;
    #1 chk("wrap_last_id", 32'(id3), 0);
    chk("wrap_last_data", d3, 100);
    @(negedge clk);

    // async reset while a result is held under backpressure
    v2 = 2'b01; op2[0] = OP_ADD; a2[0] = 32'hDE00; b2[0] = 32'h00AD; rr2 = 1'b0;
    #1 chk("dead_ready", 32'(rdy2), 32'b01);
    @(negedge clk);
    v2 = '0;
    #1 chk("dead_rv", 32'(rv2), 1);
    chk("dead_data", d2, 32'hDEAD);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rv", 32'(rv2), 0);
    chk("async_rst_data", d2, 0);
    chk("async_rst_id", 32'(id2), 0);
    @(negedge clk);
    rst_n = 1'b1; rr2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("post_rst%0d_rv", i), 32'(rv2), 0);
      @(negedge clk);
    end

    // 4 accepts to req0, 2 to req1, 3 stall cycles
    for (int i = 0; i < 9; i++) begin
      v2 = (i < 4) ? 2'b01 : (i < 6) ? 2'b10 : 2'b01;
      rr2 = (i < 6);
      op2[0] = OP_ADD; a2[0] = 32'(i); b2[0] = 1;
      op2[1] = OP_XOR; a2[1] = 32'(i); b2[1] = 3;
      #1 chk($sformatf("perf_seq%0d_ready", i), 32'(rdy2),
             (i < 4) ? 32'b01 : (i < 6) ? 32'b10 : 0);
      @(negedge clk);
    end
`ifdef ALU_SCHED_PERF_EN
    #1;
    chk("perf_grant0", pg2[0], 4);
    chk("perf_grant1", pg2[1], 2);
    chk("perf_stall", ps2, 3);
`endif
    rr2 = 1'b1;
    @(negedge clk);
    v2 = '0;

    // randomized traffic on N_REQ=3; model state follows from the last reset
    m_ptr = 0; m_rv = 1'b0; m_d = '0; m_id = '0; hold = '0;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 3; r++) begin
        if (!hold[r]) begin
          v3[r]  = ($urandom_range(0, 99) < 60);
          op3[r] = alu_op_t'(4'($urandom_range(0, 15)));
          a3[r]  = $urandom;
          b3[r]  = $urandom;
        end
      end
      rr3 = ($urandom_range(0, 99) < 70);
      g = -1;
      if (!m_rv || rr3) begin
        for (int k = 0; k < 3; k++) begin
          idx = (m_ptr + k) % 3;
          if (g < 0 && v3[2'(idx)]) g = idx;
        end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[2'(g)] = 1'b1;
      #1;
      chk($sformatf("rnd%0d_ready", c), 32'(rdy3), 32'(exp_rdy));
      chk($sformatf("rnd%0d_rv", c), 32'(rv3), 32'(m_rv));
      if (m_rv) begin
        chk($sformatf("rnd%0d_data", c), d3, m_d);
        chk($sformatf("rnd%0d_id", c), 32'(id3), 32'(m_id));
      end
      if (g < 0) chk($sformatf("rnd%0d_idle_in0", c), ai0_3, a3[0]);
      if (g >= 0) begin
        m_rv  = 1'b1;
        m_d   = alu_f(op3[2'(g)], a3[2'(g)], b3[2'(g)]);
        m_id  = 2'(g);
        m_ptr = (g + 1) % 3;
      end else if (rr3) begin
        m_rv = 1'b0;
      end
      for (int r = 0; r < 3; r++) hold[r] = v3[r] && (r != g);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
